// File: rtl/cpu_fetch_decode_pkg.sv
// Shared CPU definitions: cpu_fsm state encodings, opcode map and the fetch FSM state type.
`ifndef CPU_STATES
`define CPU_STATES 4
`endif

package cpu_fetch_decode_pkg;

    localparam int CPU_STATE_W = $clog2(`CPU_STATES);

    typedef enum logic [CPU_STATE_W-1:0] {
        CPU_FETCH  = 0,
        CPU_DECODE = 1,
        CPU_EXEC   = 2,
        CPU_WB     = 3
    } cpu_state_e;

    // Only NOP is interpreted here; the remaining opcodes are decoded by the execute stage.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_JMP = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_DONE
    } fetch_state_e;

    function automatic logic is_nop_op(input logic [3:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/cpu_fetch_decode.sv
// Instruction fetch with ack timeout plus combinational opcode/operand split of the IR.
`ifndef CPU_STATES
`define CPU_STATES 4
`endif

module cpu_fetch_decode
    import cpu_fetch_decode_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                             sys_clk,
    input  logic                             sys_reset,
    input  logic [$clog2(`CPU_STATES)-1:0]   cpu_state,
    output logic                             is_nop,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [7:0]                       mem_rdata,
    input  logic                             mem_ack,
    input  logic                             pc_load,
    input  logic [ADDR_W-1:0]                pc_next,
    output logic [3:0]                       opcode,
    output logic [3:0]                       operand,
    output logic                             stall,
    output logic                             fetch_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [7:0]        r_ir;
    logic              r_is_nop;
    logic              r_mem_req;
    logic              r_fetch_err;
    logic [CNT_W-1:0]  r_wait;

    logic              w_in_fetch;
    logic              w_busy;
    logic              w_ack_take;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_pc_d;

    assign w_in_fetch = (cpu_state == CPU_FETCH);
    assign w_busy     = (r_state == FS_REQ) || (r_state == FS_WAIT);
    assign w_ack_take = w_busy && mem_ack;
    assign w_timeout  = w_busy && !mem_ack && (r_wait == CNT_W'(ACK_TIMEOUT - 1));

    // A branch load always beats the post-fetch increment.
    assign w_pc_d = pc_load    ? pc_next :
                    w_ack_take ? r_pc + 1'b1 :
                                 r_pc;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state     <= FS_IDLE;
            r_pc        <= '0;
            r_req_addr  <= '0;
            r_ir        <= 8'h00;
            r_is_nop    <= 1'b1;
            r_mem_req   <= 1'b0;
            r_fetch_err <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_pc <= w_pc_d;
            case (r_state)
                FS_IDLE: begin
                    if (w_in_fetch) begin
                        r_state    <= FS_REQ;
                        r_mem_req  <= 1'b1;
                        r_req_addr <= w_pc_d;
                        r_wait     <= '0;
                    end
                end
                FS_REQ, FS_WAIT: begin
                    if (mem_ack) begin
                        r_state   <= FS_DONE;
                        r_mem_req <= 1'b0;
                        r_ir      <= mem_rdata;
                        r_is_nop  <= is_nop_op(mem_rdata[7:4]);
                    end else if (w_timeout) begin
                        r_state     <= FS_DONE;
                        r_mem_req   <= 1'b0;
                        r_ir        <= 8'h00;
                        r_is_nop    <= 1'b1;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_state <= FS_WAIT;
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                FS_DONE: begin
                    if (!w_in_fetch) begin
                        r_state <= FS_IDLE;
                    end
                end
                default: begin
                    r_state   <= FS_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // The outstanding request keeps its own address so a mid-fetch branch only affects the next fetch.
    assign mem_addr  = w_busy ? r_req_addr : r_pc;
    assign mem_req   = r_mem_req;
    assign stall     = r_mem_req;
    assign is_nop    = r_is_nop;
    assign fetch_err = r_fetch_err;
    assign opcode    = r_ir[7:4];
    assign operand   = r_ir[3:0];

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scenario bench for cpu_fetch_decode: directed fetch cases plus randomized fetches against a transaction model.
module tb_cpu_fetch_decode;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic [1:0] cpu_state;
    logic       is_nop;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       pc_load;
    logic [7:0] pc_next;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       stall;
    logic       fetch_err;

    int tests = 0;
    int fails = 0;

    // Transaction-level model state
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic       m_nop;
    logic       m_err;

    always #5 clk = ~clk;

    cpu_fetch_decode #(.ADDR_W(8), .ACK_TIMEOUT(T)) dut (
        .sys_clk   (clk),
        .sys_reset (sys_reset),
        .cpu_state (cpu_state),
        .is_nop    (is_nop),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .opcode    (opcode),
        .operand   (operand),
        .stall     (stall),
        .fetch_err (fetch_err)
    );

    task automatic do_reset();
        @(negedge clk);
        sys_reset = 1'b1; cpu_state = 2'd1; mem_ack = 1'b0; pc_load = 1'b0;
        pc_next = 8'h00; mem_rdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        sys_reset = 1'b0;
        m_pc = 8'h00; m_ir = 8'h00; m_nop = 1'b1; m_err = 1'b0;
    endtask

    task automatic load_pc(input logic [7:0] v);
        @(negedge clk);
        pc_load = 1'b1; pc_next = v;
        @(negedge clk);
        pc_load = 1'b0;
        m_pc = v;
    endtask

    // Drives one FETCH visit. delay: cycle of mem_req on which ack arrives (never if >= T or < 0).
    // ld_cyc: cycle of mem_req on which pc_load pulses (-1 for none).
    task automatic run_fetch(input int delay, input logic [7:0] data, input int ld_cyc,
                             input logic [7:0] ldv, output int reqc, output logic [7:0] a0,
                             output bit addr_ok, output int extra);
        bit done;
        reqc = 0; addr_ok = 1'b1; extra = 0; done = 1'b0;
        @(negedge clk);
        cpu_state = 2'd0; mem_ack = 1'b0; pc_load = 1'b0;
        @(negedge clk);
        a0 = mem_addr;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!mem_req) begin
                done = 1'b1;
            end else begin
                reqc++;
                if (mem_addr !== a0 || stall !== 1'b1) addr_ok = 1'b0;
                mem_ack   = (c == delay);
                mem_rdata = (c == delay) ? data : 8'($urandom);
                pc_load   = (c == ld_cyc);
                pc_next   = ldv;
                @(negedge clk);
                mem_ack = 1'b0; pc_load = 1'b0;
            end
        end
        // Stay in FETCH a little longer with stray acks: no second request, acks ignored.
        for (int k = 0; k < 2; k++) begin
            if (mem_req) extra++;
            mem_ack = 1'b1; mem_rdata = ~data;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        cpu_state = 2'd1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Expected effect of one FETCH visit, straight from the fetch rules.
    task automatic model_fetch(input int delay, input logic [7:0] data, input int ld_cyc,
                               input logic [7:0] ldv, output int exp_reqc);
        bit acc;
        bit loaded;
        int last;
        acc    = (delay >= 0) && (delay < T);
        last   = acc ? delay : T - 1;
        exp_reqc = last + 1;
        loaded = (ld_cyc >= 0) && (ld_cyc <= last);
        if (acc) begin
            m_ir  = data;
            m_nop = (data[7:4] == 4'h0);
            if (loaded && ld_cyc == delay) m_pc = ldv;
            else if (loaded)               m_pc = 8'(ldv + 1);
            else                           m_pc = 8'(m_pc + 1);
        end else begin
            m_ir  = 8'h00;
            m_nop = 1'b1;
            m_err = 1'b1;
            if (loaded) m_pc = ldv;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (stall !== 1'b0)     begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_pc: got %h want 00", mem_addr); end
        tests++; if ({opcode, operand} !== 8'h00) begin fails++; $display("FAIL reset_ir: got %h want 00", {opcode, operand}); end
        tests++; if (is_nop !== 1'b1)    begin fails++; $display("FAIL reset_is_nop: got %b want 1", is_nop); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_basic_fetch();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        run_fetch(2, 8'h3A, -1, 8'h00, reqc, a0, ok, extra);
        tests++; if (a0 !== 8'h00)     begin fails++; $display("FAIL basic_addr: got %h want 00", a0); end
        tests++; if (reqc !== 3)       begin fails++; $display("FAIL basic_stall_cycles: got %0d want 3", reqc); end
        tests++; if (!ok)              begin fails++; $display("FAIL basic_addr_stable: got 0 want 1"); end
        tests++; if (opcode !== 4'h3)  begin fails++; $display("FAIL basic_opcode: got %h want 3", opcode); end
        tests++; if (operand !== 4'hA) begin fails++; $display("FAIL basic_operand: got %h want a", operand); end
        tests++; if (is_nop !== 1'b0)  begin fails++; $display("FAIL basic_is_nop: got %b want 0", is_nop); end
        tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL basic_pc: got %h want 01", mem_addr); end
        tests++; if (extra !== 0)      begin fails++; $display("FAIL basic_one_fetch: got %0d want 0", extra); end
    endtask

    task automatic test_zero_wait();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        run_fetch(0, 8'h05, -1, 8'h00, reqc, a0, ok, extra);
        tests++; if (reqc !== 1)       begin fails++; $display("FAIL zw_req_cycles: got %0d want 1", reqc); end
        tests++; if (is_nop !== 1'b1)  begin fails++; $display("FAIL zw_is_nop: got %b want 1", is_nop); end
        tests++; if ({opcode, operand} !== 8'h05) begin fails++; $display("FAIL zw_ir: got %h want 05", {opcode, operand}); end
        tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL zw_pc: got %h want 01", mem_addr); end
    endtask

    task automatic test_timeout();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        load_pc(8'h20);
        run_fetch(-1, 8'hC3, -1, 8'h00, reqc, a0, ok, extra);
        tests++; if (a0 !== 8'h20)       begin fails++; $display("FAIL to_addr: got %h want 20", a0); end
        tests++; if (reqc !== T)         begin fails++; $display("FAIL to_req_cycles: got %0d want %0d", reqc, T); end
        tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL to_fetch_err: got %b want 1", fetch_err); end
        tests++; if (is_nop !== 1'b1)    begin fails++; $display("FAIL to_is_nop: got %b want 1", is_nop); end
        tests++; if ({opcode, operand} !== 8'h00) begin fails++; $display("FAIL to_ir: got %h want 00", {opcode, operand}); end
        tests++; if (mem_addr !== 8'h20) begin fails++; $display("FAIL to_pc: got %h want 20", mem_addr); end
        tests++; if (extra !== 0)        begin fails++; $display("FAIL to_done_held: got %0d want 0", extra); end
    endtask

    task automatic test_pc_wrap();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        load_pc(8'hFF);
        run_fetch(1, 8'h12, -1, 8'h00, reqc, a0, ok, extra);
        tests++; if (a0 !== 8'hFF)       begin fails++; $display("FAIL wrap_addr: got %h want ff", a0); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL wrap_pc: got %h want 00", mem_addr); end
    endtask

    task automatic test_pc_load_ack();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        run_fetch(3, 8'h47, 3, 8'h40, reqc, a0, ok, extra);
        tests++; if (mem_addr !== 8'h40) begin fails++; $display("FAIL ldack_pc: got %h want 40", mem_addr); end
        run_fetch(0, 8'h11, -1, 8'h00, reqc, a0, ok, extra);
        tests++; if (a0 !== 8'h40)       begin fails++; $display("FAIL ldack_next_addr: got %h want 40", a0); end
        tests++; if (mem_addr !== 8'h41) begin fails++; $display("FAIL ldack_next_pc: got %h want 41", mem_addr); end
    endtask

    task automatic test_pc_load_wait();
        int reqc, extra; logic [7:0] a0; bit ok;
        do_reset();
        run_fetch(4, 8'h99, 1, 8'h80, reqc, a0, ok, extra);
        tests++; if (!ok)                begin fails++; $display("FAIL ldwait_addr_stable: got 0 want 1"); end
        tests++; if (a0 !== 8'h00)       begin fails++; $display("FAIL ldwait_addr: got %h want 00", a0); end
        tests++; if (mem_addr !== 8'h81) begin fails++; $display("FAIL ldwait_pc: got %h want 81", mem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        load_pc(8'h30);
        @(negedge clk); cpu_state = 2'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmid_in_wait: got %b want 1", mem_req); end
        sys_reset = 1'b1; cpu_state = 2'd1;
        @(negedge clk);
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_mem_req: got %b want 0", mem_req); end
        tests++; if (stall !== 1'b0)   begin fails++; $display("FAIL rmid_stall: got %b want 0", stall); end
        sys_reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        tests++; if ({opcode, operand} !== 8'h00) begin fails++; $display("FAIL rmid_ir: got %h want 00", {opcode, operand}); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL rmid_pc: got %h want 00", mem_addr); end
        tests++; if (is_nop !== 1'b1)    begin fails++; $display("FAIL rmid_is_nop: got %b want 1", is_nop); end
        tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL rmid_late_ack: got %b want 0", mem_req); end
    endtask

    task automatic test_random();
        int reqc, extra, exp_reqc, delay, ld_cyc;
        logic [7:0] a0, exp_a0, data, ldv;
        bit ok;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            delay  = $urandom_range(0, T + 2);
            if (delay >= T) delay = -1;
            data   = 8'($urandom);
            ldv    = 8'($urandom);
            ld_cyc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) : -1;
            exp_a0 = m_pc;
            model_fetch(delay, data, ld_cyc, ldv, exp_reqc);
            run_fetch(delay, data, ld_cyc, ldv, reqc, a0, ok, extra);
            tests++; if (a0 !== exp_a0 || !ok) begin fails++; $display("FAIL rnd_addr[%0d]: got %h stable=%0d want %h", i, a0, ok, exp_a0); end
            tests++; if (reqc !== exp_reqc)    begin fails++; $display("FAIL rnd_req_cycles[%0d]: got %0d want %0d", i, reqc, exp_reqc); end
            tests++; if ({opcode, operand} !== m_ir) begin fails++; $display("FAIL rnd_ir[%0d]: got %h want %h", i, {opcode, operand}, m_ir); end
            tests++; if (is_nop !== m_nop)     begin fails++; $display("FAIL rnd_is_nop[%0d]: got %b want %b", i, is_nop, m_nop); end
            tests++; if (fetch_err !== m_err)  begin fails++; $display("FAIL rnd_fetch_err[%0d]: got %b want %b", i, fetch_err, m_err); end
            tests++; if (mem_addr !== m_pc)    begin fails++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, mem_addr, m_pc); end
            tests++; if (extra !== 0)          begin fails++; $display("FAIL rnd_one_fetch[%0d]: got %0d want 0", i, extra); end
        end
    endtask

    initial begin
        sys_reset = 1'b1; cpu_state = 2'd1; mem_ack = 1'b0; pc_load = 1'b0;
        pc_next = 8'h00; mem_rdata = 8'h00;
        m_pc = 8'h00; m_ir = 8'h00; m_nop = 1'b1; m_err = 1'b0;
        test_reset();
        test_basic_fetch();
        test_zero_wait();
        test_timeout();
        test_pc_wrap();
        test_pc_load_ack();
        test_pc_load_wait();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_decode.md
CPU_FETCH_DECODE -- requirements
Module: cpu_fetch_decode

Interface
REQ-001 The block SHALL declare parameter ADDR_W, default 8, program-counter and memory-address width.
REQ-002 The block SHALL declare parameter ACK_TIMEOUT, default 15, the maximum number of wait cycles for mem_ack.
REQ-003 The block SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port sys_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port cpu_state, input, $clog2(`CPU_STATES), the current state from cpu_fsm.
REQ-006 The block SHALL have port is_nop, output, 1, the NOP indication consumed by cpu_fsm.
REQ-007 The block SHALL have port mem_req, output, 1, the instruction-memory read request.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W, the read address, equal to pc.
REQ-009 The block SHALL have port mem_rdata, input, 8, the instruction byte, valid when mem_ack=1.
REQ-010 The block SHALL have port mem_ack, input, 1, the read completion from memory.
REQ-011 The block SHALL have port pc_load, input, 1, the branch/jump load strobe.
REQ-012 The block SHALL have port pc_next, input, ADDR_W, the branch target.
REQ-013 The block SHALL have port opcode, output, 4, equal to ir[7:4].
REQ-014 The block SHALL have port operand, output, 4, equal to ir[3:0].
REQ-015 The block SHALL have port stall, output, 1, high while a fetch is outstanding.
REQ-016 The block SHALL have port fetch_err, output, 1, a sticky flag set on mem_ack timeout.

Function
REQ-017 The internal FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-018 In IDLE, entry to the FETCH cpu_state SHALL cause a move to REQ on the next edge; other cpu_state values SHALL hold IDLE.
REQ-019 In REQ and WAIT, mem_req SHALL be 1, stall SHALL be 1, and mem_addr SHALL be pc, stable until the acknowledging cycle.
REQ-020 REQ SHALL move to WAIT after one cycle unless mem_ack=1, in which case it SHALL go directly to DONE; an ack in the REQ cycle is legal (zero-wait memory).
REQ-021 On a sampled mem_ack=1: ir <= mem_rdata, pc <= pc+1 (wrapping at 2^ADDR_W), mem_req=0 from the next cycle, and the FSM SHALL enter DONE.
REQ-022 is_nop SHALL be registered and SHALL equal (mem_rdata[7:4]==4'h0) at the ack edge; it SHALL hold until the next ack or timeout.
REQ-023 A wait counter SHALL count cycles in REQ/WAIT; on reaching ACK_TIMEOUT without ack: ir <= 8'h00, is_nop <= 1, fetch_err <= 1, pc unchanged, enter DONE.
REQ-024 DONE SHALL be held until cpu_state leaves FETCH, then the FSM SHALL move to IDLE; only one fetch per FETCH visit.
REQ-025 pc_load=1 SHALL set pc <= pc_next in any FSM state; if it coincides with an ack, pc_load SHALL win over the increment.
REQ-026 pc_load during REQ/WAIT SHALL NOT change mem_addr for the outstanding request; the new pc SHALL apply to the next fetch.
REQ-027 mem_ack received in IDLE or DONE SHALL be ignored.

Reset
REQ-028 While sys_reset=1 at an edge: FSM=IDLE, pc=0, ir=0, is_nop=1, mem_req=0, stall=0, fetch_err=0, wait counter=0.
REQ-029 Reset asserted mid-fetch SHALL drop mem_req the following cycle; a late ack after reset SHALL be ignored.

Structure
REQ-030 The CPU state encodings (FETCH=0, DECODE=1, EXEC=2, WB=3), `CPU_STATES, the opcode enum (NOP=4'h0), and the fetch FSM state typedef SHALL live in the shared cpu package.
REQ-031 The block SHALL be a single module with no sub-modules; the decode is combinational from ir.

Verification
REQ-032 Scenario: reset, cpu_state=FETCH, mem_ack 2 cycles after mem_req with rdata=8'h3A -> mem_addr=0, stall high 3 cycles, opcode=3, operand=A, is_nop=0, pc=1.
REQ-033 Scenario: zero-wait ack in the REQ cycle with rdata=8'h05 -> mem_req high exactly 1 cycle, is_nop=1, pc=1.
REQ-034 Scenario: no ack for ACK_TIMEOUT cycles -> fetch_err=1, is_nop=1, ir=00, pc unchanged, FSM reaches DONE.
REQ-035 Scenario: pc=8'hFF and an ack is received -> pc=8'h00.
REQ-036 Scenario: pc_load with pc_next=8'h40 in the same cycle as an ack -> pc=8'h40, and the next fetch has mem_addr=8'h40.
REQ-037 Scenario: sys_reset asserted during WAIT, then a late ack -> mem_req=0 next cycle, ir=0, pc=0, ack ignored.
